// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus transaction controller.
package cpu_bus_pkg;

  localparam int DEFAULT_TIMEOUT = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  // A TIMEOUT of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// CPU request/response port plus the encoder and AD pad side-band signals.
interface cpu_bus_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        adrcyn;
  logic [3:0]  cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        enc_error;
  logic        bus_oe;
  logic [31:0] bus_ad_i;
  logic        rdyn;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, enc_error, bus_ad_i, rdyn,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, adrcyn,
           cpu_write, cpu_addr, cpu_wdata, bus_oe
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, enc_error, bus_ad_i, rdyn,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, adrcyn,
           cpu_write, cpu_addr, cpu_wdata, bus_oe
  );

endinterface

// File: rtl/cpu_bus_timer.sv
// Clearable data-phase wait counter; holds at TIMEOUT-1 instead of wrapping.
module cpu_bus_timer
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int            CW   = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/cpu_bus_ctrl.sv
// Runs one CPU transaction at a time: address phase, data phase with timeout,
// then a single-cycle response.
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  cpu_bus_ctrl_if.slave  bus
);

  state_t      r_state;
  state_t      w_next;
  logic        w_expire;
  logic        w_to_resp;
  logic        w_err_n;
  logic [31:0] w_rdata_n;

  logic        r_adrcyn;
  logic        r_bus_oe;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [3:0]  r_cpu_write;
  logic [31:0] r_cpu_addr;
  logic [31:0] r_cpu_wdata;

  cpu_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state != ST_DATA),
    .i_inc    (r_state == ST_DATA),
    .o_expire (w_expire)
  );

  // Target ready is checked before the timeout so a late ready still succeeds.
  always_comb begin
    w_next    = r_state;
    w_to_resp = 1'b0;
    w_err_n   = 1'b0;
    w_rdata_n = '0;
    case (r_state)
      ST_IDLE: if (bus.req_valid) w_next = ST_ADDR;
      ST_ADDR: begin
        if (bus.enc_error) begin
          w_next    = ST_RESP;
          w_to_resp = 1'b1;
          w_err_n   = 1'b1;
        end else begin
          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!bus.rdyn) begin
          w_next    = ST_RESP;
          w_to_resp = 1'b1;
          w_rdata_n = (|r_cpu_write) ? 32'h0 : bus.bus_ad_i;
        end else if (w_expire) begin
          w_next    = ST_RESP;
          w_to_resp = 1'b1;
          w_err_n   = 1'b1;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Bus-facing outputs are registered from the next state to keep them glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_adrcyn    <= 1'b1;
      r_bus_oe    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_cpu_write <= '0;
      r_cpu_addr  <= '0;
      r_cpu_wdata <= '0;
    end else begin
      r_state     <= w_next;
      r_adrcyn    <= (w_next != ST_ADDR);
      r_rsp_valid <= (w_next == ST_RESP);
      r_bus_oe    <= (w_next == ST_ADDR) || ((w_next == ST_DATA) && (|r_cpu_write));
      if (w_to_resp) begin
        r_rsp_err   <= w_err_n;
        r_rsp_rdata <= w_rdata_n;
      end
      if ((r_state == ST_IDLE) && bus.req_valid) begin
        r_cpu_write <= bus.req_write;
        r_cpu_addr  <= bus.req_addr;
        r_cpu_wdata <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE) && !rst;
  assign bus.adrcyn    = r_adrcyn;
  assign bus.bus_oe    = r_bus_oe;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.cpu_write = r_cpu_write;
  assign bus.cpu_addr  = r_cpu_addr;
  assign bus.cpu_wdata = r_cpu_wdata;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Bench for cpu_bus_ctrl: default-TIMEOUT and TIMEOUT=4 instances share stimulus;
// responses are scored against a queue of expected results.
module tb_cpu_bus_ctrl;

  typedef struct {
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_ad;
    logic        enc;
    int          k;
    logic        rdyn_addr;
    logic        t4;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        enc_error;
  logic [31:0] bus_ad;
  logic        rdyn;
  logic        sel4;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[8];

  cpu_bus_ctrl_if if64();
  cpu_bus_ctrl_if if4();

  assign if64.req_valid = req_valid;
  assign if64.req_write = req_write;
  assign if64.req_addr  = req_addr;
  assign if64.req_wdata = req_wdata;
  assign if64.enc_error = enc_error;
  assign if64.bus_ad_i  = bus_ad;
  assign if64.rdyn      = rdyn;
  assign if4.req_valid  = req_valid;
  assign if4.req_write  = req_write;
  assign if4.req_addr   = req_addr;
  assign if4.req_wdata  = req_wdata;
  assign if4.enc_error  = enc_error;
  assign if4.bus_ad_i   = bus_ad;
  assign if4.rdyn       = rdyn;

  cpu_bus_ctrl dut64 (.clk(clk), .rst(rst), .bus(if64));
  cpu_bus_ctrl #(.TIMEOUT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic        s_adrcyn, s_bus_oe, s_rsp_valid, s_rsp_err;
  logic [31:0] s_rsp_rdata, s_cpu_addr, s_cpu_wdata;
  logic [3:0]  s_cpu_write;

  assign s_adrcyn    = sel4 ? if4.adrcyn    : if64.adrcyn;
  assign s_bus_oe    = sel4 ? if4.bus_oe    : if64.bus_oe;
  assign s_rsp_valid = sel4 ? if4.rsp_valid : if64.rsp_valid;
  assign s_rsp_err   = sel4 ? if4.rsp_err   : if64.rsp_err;
  assign s_rsp_rdata = sel4 ? if4.rsp_rdata : if64.rsp_rdata;
  assign s_cpu_write = sel4 ? if4.cpu_write : if64.cpu_write;
  assign s_cpu_addr  = sel4 ? if4.cpu_addr  : if64.cpu_addr;
  assign s_cpu_wdata = sel4 ? if4.cpu_wdata : if64.cpu_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (s_rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk1("rsp_err", s_rsp_err, mon_e.err);
        chk32("rsp_rdata", s_rsp_rdata, mon_e.rdata);
        chk32("rsp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  task automatic push_exp(input logic err, input logic [31:0] rdata, input int lat);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    e.acc   = cyc;
    e.lat   = lat;
    sbq.push_back(e);
  endtask

  // Returns at a falling edge with both instances idle.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(if64.req_ready && if4.req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk1("idle_wait", if64.req_ready && if4.req_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    wait_idle();
    sel4      = v.t4;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    enc_error = v.enc;
    bus_ad    = v.bus_ad;
    rdyn      = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    push_exp(v.exp_err, v.exp_rdata, v.exp_lat);
    for (int c = 0; c <= v.exp_lat; c++) begin
      rdyn = !(((v.k > 0) && (c == v.k)) || ((c == 0) && v.rdyn_addr));
      @(negedge clk);
      chk1("adrcyn", s_adrcyn, (c == 0) ? 1'b0 : 1'b1);
      chk1("bus_oe", s_bus_oe,
           (c == 0) ? 1'b1 : ((c == v.exp_lat) ? 1'b0 : (|v.wr)));
      chk1("rsp_valid_timing", s_rsp_valid, c == v.exp_lat);
      if (c == 0) begin
        chk32("cpu_write", 32'(s_cpu_write), 32'(v.wr));
        chk32("cpu_addr", s_cpu_addr, v.addr);
      end else if (c < v.exp_lat) begin
        chk32("cpu_wdata", s_cpu_wdata, v.wdata);
      end
      @(posedge clk); #1;
    end
    rdyn      = 1'b1;
    enc_error = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_adrcyn"}, if64.adrcyn, 1'b1);
    chk1({tag, "_bus_oe"}, if64.bus_oe, 1'b0);
    chk1({tag, "_rsp_valid"}, if64.rsp_valid | if4.rsp_valid, 1'b0);
    chk1({tag, "_rsp_err"}, if64.rsp_err, 1'b0);
    chk32({tag, "_rsp_rdata"}, if64.rsp_rdata, 32'h0);
    chk32({tag, "_cpu_write"}, 32'(if64.cpu_write), 32'h0);
    chk32({tag, "_cpu_addr"}, if64.cpu_addr, 32'h0);
    chk32({tag, "_cpu_wdata"}, if64.cpu_wdata, 32'h0);
    chk1({tag, "_req_ready"}, if64.req_ready, 1'b0);
  endtask

  task automatic back_to_back();
    int   accs[3];
    int   na;
    int   guard;
    logic rdy;
    na    = 0;
    guard = 0;
    wait_idle();
    sel4      = 1'b0;
    req_write = 4'b0000;
    req_addr  = 32'h0000_4000;
    req_wdata = 32'h0;
    bus_ad    = 32'h600D_CAFE;
    rdyn      = 1'b0;
    req_valid = 1'b1;
    while (na < 3 && guard < 40) begin
      rdy = if64.req_ready;
      @(posedge clk); #1;
      if (rdy) begin
        accs[na] = cyc;
        push_exp(1'b0, 32'h600D_CAFE, 2);
        na++;
        if (na == 3) req_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    chk32("b2b_accepts", 32'(na), 32'd3);
    if (na == 3) begin
      chk32("b2b_spacing_1", 32'(accs[1] - accs[0]), 32'd4);
      chk32("b2b_spacing_2", 32'(accs[2] - accs[1]), 32'd4);
    end
    repeat (6) @(negedge clk);
    rdyn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 wr       addr          wdata         bus_ad        enc   k  ra    t4    err   rdata         lat
    vecs[0] = '{4'b0000, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 2};
    vecs[1] = '{4'b0011, 32'h0000_2000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 6, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 7};
    vecs[2] = '{4'b0101, 32'h0000_3000, 32'hA5A5_A5A5, 32'h1111_1111, 1'b1, 1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1};
    vecs[3] = '{4'b0000, 32'h0000_0400, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 5};
    vecs[4] = '{4'b0000, 32'h0000_0404, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 4, 1'b0, 1'b1, 1'b0, 32'h0BAD_F00D, 5};
    vecs[5] = '{4'b0000, 32'h0000_0500, 32'h0000_0000, 32'hA5A5_5A5A, 1'b0, 2, 1'b1, 1'b0, 1'b0, 32'hA5A5_5A5A, 3};
    vecs[6] = '{4'b1111, 32'h0000_0600, 32'h89AB_CDEF, 32'h5555_5555, 1'b0, 1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 2};
    vecs[7] = '{4'b0000, 32'h0000_0700, 32'h0000_0000, 32'h1357_9BDF, 1'b0, 3, 1'b0, 1'b1, 1'b0, 32'h1357_9BDF, 4};

    sel4      = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 4'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    enc_error = 1'b0;
    bus_ad    = 32'h0;
    rdyn      = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_reset", if64.req_ready, 1'b1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while a read is waiting in the data phase.
    wait_idle();
    sel4      = 1'b0;
    req_write = 4'b0000;
    req_addr  = 32'h0000_0800;
    bus_ad    = 32'h7777_7777;
    rdyn      = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("midrst_in_data", if64.adrcyn, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk1("midrst_ready_low", if64.req_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (2) begin
      @(negedge clk);
      chk1("midrst_no_rsp", if64.rsp_valid | if4.rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("midrst_ready_after", if64.req_ready, 1'b1);

    back_to_back();

    chk32("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

Sequences one CPU transaction at a time onto the multiplexed address/data bus. Accepts a request (byte strobes, address, write data) over a valid/ready handshake and registers it onto the inputs of the `cpu_bus` encoder. Drives the address phase (`adrcyn` low), then waits in the data phase for target ready or a timeout, and returns one response per request. Sits between the CPU core port and the `cpu_bus` encoder/pad logic.

## Interface
- `TIMEOUT`, 64: maximum data-phase cycles before the transaction is aborted with an error; legal range ≥1.
- `clk`  in  1  bus clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  controller accepts request.
- `req_write`  in  4  byte write strobes; 0000 = read word.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_err`  out  1  response is an error; valid with `rsp_valid`.
- `rsp_rdata`  out  32  read data; valid with `rsp_valid`.
- `adrcyn`  out  1  address cycle, active low; to the encoder.
- `cpu_write`  out  4  registered strobes; to the encoder.
- `cpu_addr`  out  32  registered address; to the encoder.
- `cpu_wdata`  out  32  registered write data; to the encoder.
- `enc_error`  in  1  encoder illegal-strobe flag (`error_o`).
- `bus_oe`  out  1  AD pad output enable.
- `bus_ad_i`  in  32  AD pad input data.
- `rdyn`  in  1  target ready, active low.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`: latch `req_write`/`req_addr`/`req_wdata` into `cpu_write`/`cpu_addr`/`cpu_wdata`, then go to ADDR.
- **ADDR** (exactly 1 cycle)
  - `adrcyn` = 0, `bus_oe` = 1.
  - `enc_error` is sampled this cycle.
  - If `enc_error` = 1: go to RESP with err = 1 and rdata = 0. No data phase is run.
  - Otherwise: clear the wait counter and go to DATA.
- **DATA**
  - `adrcyn` = 1, `bus_oe` = |`cpu_write` (driven for writes, released for reads).
  - `rdyn` = 0 sampled: go to RESP with err = 0. rdata = `bus_ad_i` for a read, 0 for a write.
  - `rdyn` = 1 with counter = TIMEOUT-1: go to RESP with err = 1 and rdata = 0.
  - Otherwise: increment the counter.
- **RESP**
  - `rsp_valid` = 1 for exactly one cycle; `bus_oe` = 0; `adrcyn` = 1.
  - Next state is IDLE. The response has no backpressure.
- `cpu_write`/`cpu_addr`/`cpu_wdata` hold their values until the next acceptance.
- `rsp_err`/`rsp_rdata` are registered and hold until the next RESP.
- Counter width is $clog2(TIMEOUT); it saturates and never wraps.

## Timing
- Reset values:
  - state IDLE, `adrcyn` 1, `bus_oe` 0, `rsp_valid` 0, `rsp_err` 0.
  - `rsp_rdata`, `cpu_write`, `cpu_addr`, `cpu_wdata` all 0.
- `req_ready` = (state==IDLE) & ~`rst`, so it is 0 while `rst` is high.
- Accept at edge N → ADDR in cycle N+1 → DATA from N+2.
- `rdyn` low in the first DATA cycle gives `rsp_valid` in cycle N+3. Minimum spacing between acceptances is 4 cycles.
- `rdyn` is ignored outside DATA, including a low level during ADDR.
- `rdyn` going low in the same cycle that the timeout would fire: ready wins, err = 0.
- TIMEOUT=1: a single DATA cycle; `rdyn` high there gives an error.
- `rst` mid-transaction: abort. All outputs take reset values at the next edge and no `rsp_valid` is produced.
- `req_valid` while not in IDLE is ignored; the request stays pending until IDLE.

## Structure
- `cpu_bus_pkg`: state enum (IDLE/ADDR/DATA/RESP) and the default TIMEOUT constant.
- Sub-module `cpu_bus_timer`: clearable, saturating wait counter with an `expire` output (count == TIMEOUT-1).
- `cpu_bus_ctrl` does not instantiate the encoder; the top level wires it to `cpu_bus` and the AD pads.

## Test plan
- Read, `rdyn` low on the first DATA cycle, `bus_ad_i` = 32'hDEADBEEF.
  - Expect `adrcyn` low for exactly 1 cycle and `bus_oe` 0 in DATA.
  - Expect `rsp_valid` at N+3 with `rsp_rdata` = DEADBEEF, err = 0.
- Write strobe 4'b0011, wdata 32'h1234_5678, `rdyn` low after 5 DATA cycles.
  - Expect `bus_oe` 1 throughout ADDR and DATA, and `cpu_wdata` stable.
  - Expect `rsp_valid` 5 cycles later than the first-cycle case, with err = 0 and rdata = 0.
- Strobe 4'b0101 with `enc_error` = 1 in ADDR.
  - Expect RESP in the next cycle with err = 1, no DATA cycle, and `bus_oe` 0.
- `TIMEOUT` = 4, `rdyn` held high.
  - Expect exactly 4 DATA cycles, then `rsp_valid` with err = 1.
  - Repeat with `rdyn` going low on the 4th DATA cycle: expect err = 0.
- Assert `rst` during DATA of a read.
  - Expect no `rsp_valid`, all outputs at reset values next cycle, and `req_ready` 1 after `rst` falls.
  - The following back-to-back requests complete at 4-cycle spacing.
